// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the set-associative instruction cache.
//   state_t          controller states (IDLE, MISS_REQ, FILL)
//   off_w/idx_w/tag_w address field widths derived from the geometry
//   CNT_W            width of the saturating miss counter
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MISS_REQ = 2'd1,
      FILL     = 2'd2
   } state_t;

   localparam int CNT_W = 16;

   // byte offset within a line: word select plus the two ignored byte bits
   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_words, input int sets);
      return addr_w - idx_w(sets) - off_w(line_words);
   endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the cache -- valid bits, tags and line data per set.
//   clk, rst      clock, synchronous active-high reset (valid bits only)
//   flush         clear every valid bit; a write in the same cycle survives
//   we/widx/wtag/wline   synchronous line install
//   ridx/rtag     combinational lookup; rvalid/rhit/rline describe set ridx
module icache_way #(
   parameter int SETS   = 4,
   parameter int IDX_W  = 2,
   parameter int TAG_W  = 26,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [LINE_W-1:0] wline,
   input  logic [IDX_W-1:0]  ridx,
   input  logic [TAG_W-1:0]  rtag,
   output logic              rvalid,
   output logic              rhit,
   output logic [LINE_W-1:0] rline
);

   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags [SETS];
   logic [LINE_W-1:0] data [SETS];

   // the install is ordered after the flush so the line being written stays valid
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else begin
         if (flush) valid <= '0;
         if (we)    valid[widx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[widx] <= wtag;
         data[widx] <= wline;
      end
   end

   assign rvalid = valid[ridx];
   assign rhit   = valid[ridx] && (tags[ridx] == rtag);
   assign rline  = data[ridx];

endmodule

// File: rtl/ins_cache_sa.sv
// ins_cache_sa: 1- or 2-way set-associative instruction cache, single
// outstanding miss, one-cycle hit latency.
//   clk, rst            clock, synchronous active-high reset
//   ireq/iaddr          fetch request (byte address, bits [1:0] ignored)
//   iflush              invalidate every line
//   ohit/oins           registered fetch result; oins holds when ohit=0
//   obusy               miss outstanding, requests ignored
//   omem_req/omem_addr  line refill request (line-aligned)
//   imem_valid/imem_line refill return pulse, word 0 in the LSBs
//   omiss_cnt           saturating miss count
module ins_cache_sa
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 4,
   parameter int WAYS       = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ireq,
   input  logic [ADDR_W-1:0]       iaddr,
   input  logic                    iflush,
   output logic                    ohit,
   output logic [31:0]             oins,
   output logic                    obusy,
   output logic                    omem_req,
   output logic [ADDR_W-1:0]       omem_addr,
   input  logic                    imem_valid,
   input  logic [32*LINE_WORDS-1:0] imem_line,
   output logic [CNT_W-1:0]        omiss_cnt
);

   localparam int OFF    = off_w(LINE_WORDS);
   localparam int IDX    = idx_w(SETS);
   localparam int TAG    = tag_w(ADDR_W, LINE_WORDS, SETS);
   localparam int WRD    = OFF - 2;
   localparam int LINE_W = 32 * LINE_WORDS;

   state_t state, state_nx;

   logic [TAG-1:0] a_tag, cap_tag;
   logic [IDX-1:0] a_set, cap_set, ridx;
   logic [WRD-1:0] a_word, cap_word;
   logic           unused_addr_lsb;

   logic [WAYS-1:0]             rvalid, rhit, way_we;
   logic [WAYS-1:0][LINE_W-1:0] rline;
   logic [LINE_W-1:0]           hit_line;
   logic [SETS-1:0]             lru;        // per set: index of least-recently-used way
   logic                        hit_way, victim, fill_way;
   logic                        hit_now, miss_now, fill_now;

   assign a_tag           = iaddr[ADDR_W-1:OFF+IDX];
   assign a_set           = iaddr[OFF+IDX-1:OFF];
   assign a_word          = iaddr[OFF-1:2];
   assign unused_addr_lsb = ^iaddr[1:0];

   // lookups use the request address in IDLE; during a miss the captured
   // set drives the port so victim selection sees that set's valid bits
   assign ridx = (state == IDLE) ? a_set : cap_set;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
         .SETS(SETS), .IDX_W(IDX), .TAG_W(TAG), .LINE_W(LINE_W)
      ) u_way (
         .clk   (clk),
         .rst   (rst),
         .flush (iflush),
         .we    (way_we[w]),
         .widx  (cap_set),
         .wtag  (cap_tag),
         .wline (imem_line),
         .ridx  (ridx),
         .rtag  (a_tag),
         .rvalid(rvalid[w]),
         .rhit  (rhit[w]),
         .rline (rline[w])
      );
      assign way_we[w] = fill_now && (victim == 1'(w));
   end

   // a flush in the same cycle turns any request into a miss
   assign hit_now  = (state == IDLE) && ireq && !iflush && (|rhit);
   assign miss_now = (state == IDLE) && ireq && !hit_now;
   assign fill_now = (state == MISS_REQ) && imem_valid;

   assign hit_way = (WAYS == 2) ? rhit[WAYS-1] : 1'b0;
   assign victim  = (WAYS == 2 && rvalid[0]) ? (rvalid[WAYS-1] ? lru[cap_set] : 1'b1) : 1'b0;

   always_comb begin
      hit_line = '0;
      for (int w = 0; w < WAYS; w++)
         if (rhit[w]) hit_line = hit_line | rline[w];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (miss_now) state_nx = MISS_REQ;
         MISS_REQ: if (imem_valid) state_nx = FILL;
         FILL:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign obusy    = (state == MISS_REQ);
   assign omem_req = (state == MISS_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         ohit      <= 1'b0;
         oins      <= '0;
         omem_addr <= '0;
         omiss_cnt <= '0;
         lru       <= '0;
         fill_way  <= 1'b0;
         cap_tag   <= '0;
         cap_set   <= '0;
         cap_word  <= '0;
      end else begin
         ohit <= hit_now | fill_now;
         if (hit_now)       oins <= hit_line[{a_word, 5'd0} +: 32];
         else if (fill_now) oins <= imem_line[{cap_word, 5'd0} +: 32];

         if (miss_now) begin
            cap_tag   <= a_tag;
            cap_set   <= a_set;
            cap_word  <= a_word;
            omem_addr <= {a_tag, a_set, {OFF{1'b0}}};
            if (omiss_cnt != '1) omiss_cnt <= omiss_cnt + 1'b1;
         end

         if (fill_now) fill_way <= victim;

         // flush beats the MRU update, including the one due in FILL
         if (iflush)              lru <= '0;
         else if (hit_now)        lru[a_set]   <= ~hit_way;
         else if (state == FILL)  lru[cap_set] <= ~fill_way;
      end
   end

endmodule

// File: doc/ins_cache_sa.md
INS_CACHE_SA -- requirements
Module: ins_cache_sa

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
REQ-003 Parameter SETS, 4, number of sets; power of two, at least 2.
REQ-004 Parameter WAYS, 2, associativity; legal values are 1 and 2.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ireq  in  1  fetch request valid.
REQ-008 iaddr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
REQ-009 iflush  in  1  invalidate all lines.
REQ-010 ohit  out  1  oins is valid for the accepted request.
REQ-011 oins  out  32  fetched instruction.
REQ-012 obusy  out  1  miss in progress; ireq is ignored while high.
REQ-013 omem_req  out  1  line refill request to memory.
REQ-014 omem_addr  out  ADDR_W  line-aligned refill address; offset bits are zero.
REQ-015 imem_valid  in  1  imem_line is valid; a one-cycle pulse.
REQ-016 imem_line  in  32*LINE_WORDS  refill data; word 0 is in the least significant bits.
REQ-017 omiss_cnt  out  16  saturating miss counter.

Function
REQ-018 Address split:
- OFF = log2(LINE_WORDS)+2, IDX = log2(SETS), TAG = ADDR_W-IDX-OFF.
- word = iaddr[OFF-1:2], set = iaddr[OFF+IDX-1:OFF], tag = iaddr[ADDR_W-1:OFF+IDX].
REQ-019 Per way and set, the block SHALL store a valid bit, a tag and a line; per set, one LRU bit (used only when WAYS=2).
REQ-020 States: IDLE, MISS_REQ, FILL.
REQ-021 Hit: ireq in IDLE with a valid way whose tag matches -> next cycle ohit=1, oins=selected word; state stays IDLE (1-cycle latency).
REQ-022 Hit updates LRU: the way not hit becomes LRU.
REQ-023 Miss: ireq in IDLE with no match -> next cycle ohit=0, obusy=1, omem_req=1, omem_addr={tag,set,OFF zeros}; iaddr is captured internally; state goes to MISS_REQ.
REQ-024 omem_req and omem_addr SHALL hold stable until the cycle imem_valid=1.
REQ-025 imem_valid in MISS_REQ:
- write imem_line, captured tag and valid=1 into the victim way;
- deassert omem_req; go to FILL.
REQ-026 FILL lasts one cycle: ohit=1, oins=captured word from the installed line, obusy=0, mark the installed way most-recently used; go to IDLE.
REQ-027 Victim choice: the lowest-index invalid way if one exists, else the LRU way; with WAYS=1 the victim is always way 0.
REQ-028 ohit=0 on every cycle not covered by REQ-021 or REQ-026; oins holds its last value when ohit=0.
REQ-029 ireq is ignored while obusy=1; no request queuing.
REQ-030 imem_valid outside MISS_REQ is ignored.
REQ-031 iflush clears all valid and LRU bits in one cycle, in any state.
REQ-032 Simultaneous iflush and ireq in IDLE: the flush wins; the request is treated as a miss.
REQ-033 iflush during MISS_REQ: the refill continues; the returned line is installed valid.
REQ-034 iflush in the same cycle as the line write: the flush clears every line except the one being installed.
REQ-035 omiss_cnt increments once per miss, at the IDLE->MISS_REQ transition, and saturates at 16'hFFFF.

Reset
REQ-036 rst=1 at a clock edge:
- state=IDLE; all valid and LRU bits=0;
- ohit=0, oins=0, obusy=0, omem_req=0, omem_addr=0, omiss_cnt=0.
REQ-037 Reset during MISS_REQ abandons the refill; a later imem_valid is ignored by REQ-030.
REQ-038 Tag and data arrays need not be reset.

Structure
REQ-039 Package icache_pkg: state encoding, the OFF/IDX/TAG width functions, and the counter width constant.
REQ-040 One sub-module, icache_way: a tag/valid/data array for one way with a synchronous write port and a combinational read/compare; the top instantiates WAYS copies plus the LRU logic and the state machine.

Verification (default parameters)
REQ-041 Cold miss:
- reset, ireq with iaddr=0x100 -> next cycle omem_req=1, omem_addr=0x100, obusy=1;
- imem_valid with line {D3,D2,D1,D0} -> next cycle ohit=1, oins=D0, omiss_cnt=1.
REQ-042 Hit after fill: ireq with iaddr=0x10C -> 1 cycle later ohit=1, oins=D3, omem_req stays 0.
REQ-043 Two-way conflict and LRU:
- fill 0x000, then 0x040, then re-hit 0x000;
- miss 0x080 -> refill replaces 0x040; then 0x000 hits and 0x040 misses.
REQ-044 Flush:
- filled cache, iflush=1 with ireq to 0x100 -> treated as a miss, omem_req=1;
- iflush during MISS_REQ -> the refilled line hits afterward.
REQ-045 Reset and saturation:
- rst during MISS_REQ -> omem_req=0 next cycle; a stray imem_valid installs nothing;
- force 65536 misses -> omiss_cnt=0xFFFF.
